// File: rtl/pkt_gate_pkg.sv
// -----------------------------------------------------------------------------
// pkt_gate_pkg
// Shared definitions for the store-and-forward packet gate:
//   - default data width and buffer depth (log2) constants
//   - write-side FSM state encoding
// -----------------------------------------------------------------------------
package pkt_gate_pkg;

    localparam int PKT_GATE_WIDTH = 64;
    localparam int PKT_GATE_SIZE  = 10;

    typedef enum logic {
        ST_ACCEPT = 1'b0,
        ST_DROP   = 1'b1
    } state_t;

endpackage

// File: rtl/axi_packet_gate_if.sv
// -----------------------------------------------------------------------------
// axi_packet_gate_if
// Bundles the write-side and read-side AXI-stream signals of the packet gate.
//   i_tdata/i_tlast/i_tvalid/i_terror : write side, driven by the producer
//   i_tready                          : write-side back-pressure from the gate
//   o_tdata/o_tlast/o_tvalid          : read side, driven by the gate
//   o_tready                          : read-side back-pressure from the consumer
//   o_dropped                         : one-cycle pulse per discarded packet
// Modports: slave = the gate's view, master = the environment's view.
// -----------------------------------------------------------------------------
interface axi_packet_gate_if
    import pkt_gate_pkg::*;
#(
    parameter int WIDTH = PKT_GATE_WIDTH
);
    logic [WIDTH-1:0] i_tdata;
    logic             i_tlast;
    logic             i_tvalid;
    logic             i_tready;
    logic             i_terror;
    logic [WIDTH-1:0] o_tdata;
    logic             o_tlast;
    logic             o_tvalid;
    logic             o_tready;
    logic             o_dropped;

    modport slave (
        input  i_tdata, i_tlast, i_tvalid, i_terror, o_tready,
        output i_tready, o_tdata, o_tlast, o_tvalid, o_dropped
    );

    modport master (
        output i_tdata, i_tlast, i_tvalid, i_terror, o_tready,
        input  i_tready, o_tdata, o_tlast, o_tvalid, o_dropped
    );
endinterface

// File: rtl/pkt_gate_ram.sv
// -----------------------------------------------------------------------------
// pkt_gate_ram
// Simple dual-port RAM, one write port and one registered read port, written
// so that synthesis maps it onto block RAM (no reset on the array or read reg).
//   clk              : clock
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr    : read request; rd_data is valid the cycle after rd_en
//   rd_data          : read register, holds its value while rd_en is low
// -----------------------------------------------------------------------------
module pkt_gate_ram #(
    parameter int DW = 65,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);
    localparam int DEPTH = 32'd1 << AW;

    logic [DW-1:0] mem_q [0:DEPTH-1];
    logic [DW-1:0] rd_data_q;

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Registered read port; the register holds while no read is requested.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/axi_packet_gate.sv
// -----------------------------------------------------------------------------
// axi_packet_gate
// Store-and-forward AXI-stream packet gate: beats are buffered and released on
// the read side only after the packet's tlast beat has been accepted. Packets
// too large for the buffer are discarded and reported on o_dropped.
//   clk   : clock, rising edge
//   reset : asynchronous reset, active high
//   clear : synchronous flush of all buffered data
//   bus   : axi_packet_gate_if.slave (write side i_*, read side o_*, o_dropped)
// Build option: define PKT_GATE_ERROR_DROP_EN to discard packets whose tlast
// beat carries i_terror=1; otherwise i_terror is ignored.
// -----------------------------------------------------------------------------
module axi_packet_gate
    import pkt_gate_pkg::*;
#(
    parameter int WIDTH = PKT_GATE_WIDTH,
    parameter int SIZE  = PKT_GATE_SIZE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    axi_packet_gate_if.slave bus
);
    localparam logic [SIZE-1:0] PTR_ZERO = {SIZE{1'b0}};
    localparam logic [SIZE-1:0] PTR_ONE  = {{(SIZE-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [SIZE-1:0]  wr_addr_q, wr_addr_d;
    logic [SIZE-1:0]  wr_commit_q, wr_commit_d;
    logic [SIZE-1:0]  rd_addr_q, rd_addr_d;
    logic             ready_en_q, ready_en_d;
    logic             s1_valid_q, s1_valid_d;
    logic             o_tvalid_q, o_tvalid_d;
    logic             o_tlast_q, o_tlast_d;
    logic [WIDTH-1:0] o_tdata_q, o_tdata_d;
    logic             o_dropped_q, o_dropped_d;

    logic             full_s;
    logic             in_ready_s;
    logic             wr_fire_s;
    logic             wr_en_s;
    logic             avail_s;
    logic             s2_load_s;
    logic             rd_en_s;
    logic [WIDTH:0]   ram_rdata_s;

    // Full is taken from registered pointers only, so a read in the same cycle
    // never frees room for a write.
    assign full_s     = (wr_addr_q + PTR_ONE) == rd_addr_q;
    assign in_ready_s = ready_en_q && ((state_q == ST_DROP) || !full_s);
    assign wr_fire_s  = bus.i_tvalid && in_ready_s;
    assign wr_en_s    = wr_fire_s && (state_q == ST_ACCEPT) && !clear;

    // Read pipeline: stage 1 is the RAM read register, stage 2 the output
    // register. Stage 1 may refill whenever it is empty or drains this cycle.
    assign avail_s    = rd_addr_q != wr_commit_q;
    assign s2_load_s  = s1_valid_q && (!o_tvalid_q || bus.o_tready);
    assign rd_en_s    = avail_s && (!s1_valid_q || s2_load_s) && !clear;

    pkt_gate_ram #(
        .DW (WIDTH + 1),
        .AW (SIZE)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_addr (wr_addr_q),
        .wr_data ({bus.i_tlast, bus.i_tdata}),
        .rd_en   (rd_en_s),
        .rd_addr (rd_addr_q),
        .rd_data (ram_rdata_s)
    );

    // Write-side FSM: buffering, commit on tlast, overflow and error drops.
    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        wr_commit_d = wr_commit_q;
        ready_en_d  = 1'b1;
        o_dropped_d = 1'b0;
        if (clear) begin
            state_d     = ST_ACCEPT;
            wr_addr_d   = PTR_ZERO;
            wr_commit_d = PTR_ZERO;
        end else begin
            case (state_q)
                ST_ACCEPT: begin
                    if (wr_fire_s) begin
                        wr_addr_d = wr_addr_q + PTR_ONE;
                        if (bus.i_tlast) begin
`ifdef PKT_GATE_ERROR_DROP_EN
                            if (bus.i_terror) begin
                                wr_addr_d   = wr_commit_q;
                                o_dropped_d = 1'b1;
                            end else begin
                                wr_commit_d = wr_addr_q + PTR_ONE;
                            end
`else
                            wr_commit_d = wr_addr_q + PTR_ONE;
`endif
                        end else begin
                            wr_commit_d = wr_commit_q;
                        end
                    end else if (full_s && (wr_commit_q == rd_addr_q)) begin
                        // Nothing committed is left to read, yet the partial
                        // packet fills the buffer: it can never complete.
                        state_d   = ST_DROP;
                        wr_addr_d = wr_commit_q;
                    end else begin
                        state_d = ST_ACCEPT;
                    end
                end
                ST_DROP: begin
                    if (wr_fire_s && bus.i_tlast) begin
                        state_d     = ST_ACCEPT;
                        o_dropped_d = 1'b1;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
                default: begin
                    state_d = ST_ACCEPT;
                end
            endcase
        end
    end

    // Read side: pointer advance and the two-stage prefetch.
    always_comb begin
        rd_addr_d  = rd_addr_q;
        s1_valid_d = s1_valid_q;
        o_tvalid_d = o_tvalid_q;
        o_tdata_d  = o_tdata_q;
        o_tlast_d  = o_tlast_q;
        if (clear) begin
            rd_addr_d  = PTR_ZERO;
            s1_valid_d = 1'b0;
            o_tvalid_d = 1'b0;
        end else begin
            if (rd_en_s) begin
                rd_addr_d  = rd_addr_q + PTR_ONE;
                s1_valid_d = 1'b1;
            end else if (s2_load_s) begin
                s1_valid_d = 1'b0;
            end else begin
                s1_valid_d = s1_valid_q;
            end
            if (s2_load_s) begin
                o_tvalid_d = 1'b1;
                o_tdata_d  = ram_rdata_s[WIDTH-1:0];
                o_tlast_d  = ram_rdata_s[WIDTH];
            end else if (bus.o_tready) begin
                o_tvalid_d = 1'b0;
            end else begin
                o_tvalid_d = o_tvalid_q;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_ACCEPT;
            wr_addr_q   <= PTR_ZERO;
            wr_commit_q <= PTR_ZERO;
            rd_addr_q   <= PTR_ZERO;
            ready_en_q  <= 1'b0;
            s1_valid_q  <= 1'b0;
            o_tvalid_q  <= 1'b0;
            o_tlast_q   <= 1'b0;
            o_tdata_q   <= {WIDTH{1'b0}};
            o_dropped_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            wr_commit_q <= wr_commit_d;
            rd_addr_q   <= rd_addr_d;
            ready_en_q  <= ready_en_d;
            s1_valid_q  <= s1_valid_d;
            o_tvalid_q  <= o_tvalid_d;
            o_tlast_q   <= o_tlast_d;
            o_tdata_q   <= o_tdata_d;
            o_dropped_q <= o_dropped_d;
        end
    end

`ifndef PKT_GATE_ERROR_DROP_EN
    logic unused_terror_s;
    assign unused_terror_s = bus.i_terror;
`endif

    assign bus.i_tready  = in_ready_s;
    assign bus.o_tdata   = o_tdata_q;
    assign bus.o_tlast   = o_tlast_q;
    assign bus.o_tvalid  = o_tvalid_q;
    assign bus.o_dropped = o_dropped_q;
endmodule

// File: tb/tb_axi_packet_gate.sv
// -----------------------------------------------------------------------------
// tb_axi_packet_gate
// Self-checking bench for axi_packet_gate (WIDTH=16, SIZE=4). A packet-level
// reference model predicts delivered beats and drop count: a packet is
// delivered unless it is longer than the usable depth (2^SIZE-1 beats) or,
// with PKT_GATE_ERROR_DROP_EN, flagged with i_terror on its tlast beat.
// -----------------------------------------------------------------------------
module tb_axi_packet_gate;
    localparam int W     = 16;
    localparam int S     = 4;
    localparam int DEPTH = 32'd1 << S;

    logic clk;
    logic reset;
    logic clear;

    axi_packet_gate_if #(.WIDTH(W)) bus ();

    axi_packet_gate #(
        .WIDTH (W),
        .SIZE  (S)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int seen_drops = 0;
    int exp_drops = 0;
    logic [W:0] exp_q [$];
    logic [W:0] cur_q [$];
    bit rand_rdy = 1'b0;
    logic rdy_val = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare observed against expected and report any mismatch.
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Read-side ready driver.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            bus.o_tready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_val;
        end
    end

    // Reference model and scoreboard, sampled mid-cycle.
    initial begin
        logic [W:0] e;
        bit bad;
        forever begin
            @(negedge clk);
            if (reset || clear) begin
                exp_q.delete();
                cur_q.delete();
            end else begin
                if (bus.o_tvalid && bus.o_tready) begin
                    if (exp_q.size() == 0) begin
                        chk("rd_spurious", {63'd0, bus.o_tvalid}, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rd_beat", {47'd0, bus.o_tlast, bus.o_tdata}, {47'd0, e});
                    end
                end
                if (bus.o_dropped) seen_drops++;
                if (bus.i_tvalid && bus.i_tready) begin
                    cur_q.push_back({bus.i_tlast, bus.i_tdata});
                    if (bus.i_tlast) begin
                        bad = (cur_q.size() > DEPTH - 1);
`ifdef PKT_GATE_ERROR_DROP_EN
                        bad = bad || bus.i_terror;
`endif
                        if (bad) exp_drops++;
                        else foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
                        cur_q.delete();
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    task automatic send_beat(input logic [W-1:0] d, input logic l, input logic e, output bit stalled);
        int n;
        stalled = 1'b0;
        n = 0;
        bus.i_tvalid = 1'b1;
        bus.i_tdata  = d;
        bus.i_tlast  = l;
        bus.i_terror = e;
        @(negedge clk);
        while (!bus.i_tready && n < 300) begin
            stalled = 1'b1;
            n++;
            @(negedge clk);
        end
        if (n >= 300) chk("wr_timeout", 64'(n), 64'd0);
        @(posedge clk);
        #1;
        bus.i_tvalid = 1'b0;
        bus.i_tlast  = 1'b0;
        bus.i_terror = 1'b0;
    endtask

    task automatic send_pkt(input int len, input logic [W-1:0] base, input logic err,
                            input bit gaps, output bit stalled);
        bit s;
        stalled = 1'b0;
        for (int i = 0; i < len; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send_beat(base + W'(i), (i == len - 1), err && (i == len - 1), s);
            stalled |= s;
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.o_tvalid) && n < 600) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({"drain_", tag}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        bit st;
        bit any_v;
        int d0;
        reset = 1'b1;
        clear = 1'b0;
        bus.i_tvalid = 1'b0;
        bus.i_tdata  = '0;
        bus.i_tlast  = 1'b0;
        bus.i_terror = 1'b0;
        bus.o_tready = 1'b1;

        // Reset values.
        cycles(3);
        chk("rst_i_tready", {63'd0, bus.i_tready}, 64'd0);
        chk("rst_o_tvalid", {63'd0, bus.o_tvalid}, 64'd0);
        chk("rst_o_dropped", {63'd0, bus.o_dropped}, 64'd0);
        chk("rst_o_tdata", 64'(bus.o_tdata), 64'd0);
        chk("rst_o_tlast", {63'd0, bus.o_tlast}, 64'd0);
        #2 reset = 1'b0;
        cycles(1);
        chk("ready_after_rst", {63'd0, bus.i_tready}, 64'd1);

        // 4-beat packet: latency of two cycles after commit, back-to-back read.
        send_pkt(4, 16'h0010, 1'b0, 1'b0, st);
        chk("lat_c0_valid", {63'd0, bus.o_tvalid}, 64'd0);
        cycles(1);
        chk("lat_c1_valid", {63'd0, bus.o_tvalid}, 64'd0);
        cycles(1);
        chk("lat_c2_valid", {63'd0, bus.o_tvalid}, 64'd1);
        chk("lat_c2_data", 64'(bus.o_tdata), 64'h10);
        cycles(1);
        chk("stream_b1", 64'(bus.o_tdata), 64'h11);
        cycles(1);
        chk("stream_b2", 64'(bus.o_tdata), 64'h12);
        cycles(1);
        chk("stream_b3", {47'd0, bus.o_tlast, bus.o_tdata}, {47'd0, 1'b1, 16'h0013});
        drain("pkt4");

        // Incomplete packet is held back until its tlast arrives.
        for (int i = 0; i < 3; i++) send_beat(16'h0020 + 16'(i), 1'b0, 1'b0, st);
        any_v = 1'b0;
        repeat (20) begin @(posedge clk); #1; any_v |= bus.o_tvalid; end
        chk("hold_partial", {63'd0, any_v}, 64'd0);
        send_beat(16'h0023, 1'b1, 1'b0, st);
        drain("partial");

        // Overflow: 20-beat packet is discarded, following packet survives.
        d0 = seen_drops;
        send_pkt(20, 16'h0100, 1'b0, 1'b0, st);
        chk("ovf_stall", {63'd0, st}, 64'd1);
        send_pkt(2, 16'h0200, 1'b0, 1'b0, st);
        drain("ovf");
        chk("ovf_drop_once", 64'(seen_drops - d0), 64'd1);

        // Error-flagged packet between two good ones.
        d0 = seen_drops;
        send_pkt(3, 16'h0A00, 1'b0, 1'b0, st);
        send_pkt(2, 16'h0B00, 1'b1, 1'b0, st);
        send_pkt(4, 16'h0C00, 1'b0, 1'b0, st);
        drain("err");
`ifdef PKT_GATE_ERROR_DROP_EN
        chk("err_drop", 64'(seen_drops - d0), 64'd1);
`else
        chk("err_drop", 64'(seen_drops - d0), 64'd0);
`endif

        // Randomized traffic with random read back-pressure.
        rand_rdy = 1'b1;
        for (int p = 0; p < 30; p++) begin
            send_pkt($urandom_range(1, 18), W'($urandom), 1'($urandom_range(0, 3) == 0), 1'b1, st);
        end
        rand_rdy = 1'b0;
        rdy_val  = 1'b1;
        cycles(2);
        drain("random");

        // Clear mid-read with a second packet committed.
        rdy_val = 1'b0;
        send_pkt(6, 16'h0040, 1'b0, 1'b0, st);
        send_pkt(3, 16'h0050, 1'b0, 1'b0, st);
        cycles(4);
        chk("stall_valid", {63'd0, bus.o_tvalid}, 64'd1);
        chk("stall_data", 64'(bus.o_tdata), 64'h40);
        cycles(3);
        chk("stall_hold", 64'(bus.o_tdata), 64'h40);
        rdy_val = 1'b1;
        cycles(3);
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
        chk("clear_valid", {63'd0, bus.o_tvalid}, 64'd0);
        any_v = 1'b0;
        repeat (20) begin @(posedge clk); #1; any_v |= bus.o_tvalid; end
        chk("clear_quiet", {63'd0, any_v}, 64'd0);
        send_pkt(2, 16'h0060, 1'b0, 1'b0, st);
        drain("after_clear");

        // Asynchronous reset mid-packet with data waiting at the output.
        rdy_val = 1'b0;
        send_pkt(2, 16'h0070, 1'b0, 1'b0, st);
        send_beat(16'h0080, 1'b0, 1'b0, st);
        send_beat(16'h0081, 1'b0, 1'b0, st);
        cycles(3);
        chk("pre_rst_valid", {63'd0, bus.o_tvalid}, 64'd1);
        d0 = seen_drops;
        #3 reset = 1'b1;
        #1;
        chk("arst_valid", {63'd0, bus.o_tvalid}, 64'd0);
        chk("arst_ready", {63'd0, bus.i_tready}, 64'd0);
        chk("arst_tdata", 64'(bus.o_tdata), 64'd0);
        cycles(2);
        reset = 1'b0;
        rdy_val = 1'b1;
        cycles(2);
        send_pkt(3, 16'h0090, 1'b0, 1'b0, st);
        drain("after_rst");
        chk("arst_no_drop", 64'(seen_drops - d0), 64'd0);

        chk("drops_total", 64'(seen_drops), 64'(exp_drops));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
